// File: rtl/pb_pkg.sv
// Shared types and helpers for the multi-channel push-button conditioner.
// Defines the per-channel FSM states, the per-channel event bundle and the timer-width rule.
package pb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_CNT = 3'd1,
    PRESSED   = 3'd2,
    HOLD      = 3'd3,
    LONG      = 3'd4,
    REPEAT    = 3'd5,
    REL_CNT   = 3'd6,
    RELEASED  = 3'd7
  } pb_state_t;

  // Everything one channel reports to the top in a given cycle.
  typedef struct packed {
    logic status;
    logic press;
    logic rel;
    logic lng;
    logic rpt;
  } pb_evt_t;

  // The widest terminal count must fit, so the timer spans clog2 of the largest delay.
  function automatic int timer_w(input int delay, input int long_delay, input int repeat_period);
    int m;
    m = (delay > long_delay) ? delay : long_delay;
    m = (m > repeat_period) ? m : repeat_period;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One push-button channel: 2-FF synchroniser, shared state timer and debounce FSM.
// Both edges are debounced; long-press and auto-repeat events are derived from the hold time.
module pb_debounce_ch
  import pb_pkg::*;
#(
  parameter int DELAY         = 15,
  parameter int LONG_DELAY    = 1000,
  parameter int REPEAT_PERIOD = 200,
  parameter bit REPEAT_EN     = 1'b1,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    pb,
  output pb_evt_t evt
);

  localparam int            TW         = timer_w(DELAY, LONG_DELAY, REPEAT_PERIOD);
  localparam logic [TW-1:0] DELAY_LAST = TW'(DELAY - 1);
  localparam logic [TW-1:0] LONG_LAST  = TW'(LONG_DELAY - 1);
  localparam logic [TW-1:0] REP_LAST   = TW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  logic [1:0]    sync_q;
  logic          s;
  pb_state_t     state_q, state_d;
  logic [TW-1:0] timer_q;
  logic          rpt_wrap;

  // NOTE: synchroniser flops get a reset value too, the idle raw level, so a button
  // that is merely idle never looks like a press right after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {2{ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[0], pb};
    end
  end

  // Normalised so that 1 always means "pressed".
  assign s = sync_q[1] ^ ACTIVE_LOW;

  assign rpt_wrap = (state_q == REPEAT) && s && (timer_q == REP_LAST);

  // NOTE: non-blocking assignments here so every flop samples pre-edge values,
  // independent of statement order and of other always_ff blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || rpt_wrap) begin
        timer_q <= '0;
      end else if (timer_q != TIMER_MAX) begin
        timer_q <= timer_q + TW'(1);
      end
    end
  end

  // NOTE: state_d is defaulted first so every path assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (s) state_d = PRESS_CNT;
      PRESS_CNT: begin
        if (!s)                         state_d = IDLE;
        else if (timer_q == DELAY_LAST) state_d = PRESSED;
      end
      PRESSED:   state_d = HOLD;
      HOLD: begin
        if (!s)                        state_d = REL_CNT;
        else if (timer_q == LONG_LAST) state_d = LONG;
      end
      LONG:      state_d = REPEAT;
      REPEAT:    if (!s) state_d = REL_CNT;
      // A bounce back to pressed is a release glitch: resume holding with a fresh count.
      REL_CNT: begin
        if (s)                          state_d = HOLD;
        else if (timer_q == DELAY_LAST) state_d = RELEASED;
      end
      RELEASED:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    evt        = '0;
    evt.status = (state_q == PRESSED) || (state_q == HOLD) || (state_q == LONG) ||
                 (state_q == REPEAT)  || (state_q == REL_CNT);
    evt.press  = (state_q == PRESSED);
    evt.rel    = (state_q == RELEASED);
    evt.lng    = (state_q == LONG);
    evt.rpt    = rpt_wrap && REPEAT_EN;
  end

  pulse_onehot_a : assert property (@(posedge clk) disable iff (!rst)
    $onehot0({evt.press, evt.rel, evt.lng, evt.rpt}));

endmodule

// File: rtl/pb_debouncer_multi.sv
// Multi-channel push-button conditioner: N_CH independent debounce channels plus an any-pressed flag.
// Channels share only clock and reset, so simultaneous events are reported in the same cycle.
module pb_debouncer_multi
  import pb_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DELAY         = 15,
  parameter int LONG_DELAY    = 1000,
  parameter int REPEAT_PERIOD = 200,
  parameter int REPEAT_EN     = 1,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] pressed_status,
  output logic [N_CH-1:0] pressed_pulse,
  output logic [N_CH-1:0] released_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_pressed
);

  if (N_CH < 1) begin : g_bad_n_ch
    $error("pb_debouncer_multi: N_CH must be >= 1");
  end
  if (DELAY < 2) begin : g_bad_delay
    $error("pb_debouncer_multi: DELAY must be >= 2");
  end
  if (LONG_DELAY <= DELAY) begin : g_bad_long
    $error("pb_debouncer_multi: LONG_DELAY must exceed DELAY");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_repeat
    $error("pb_debouncer_multi: REPEAT_PERIOD must be >= 2");
  end
  if ((REPEAT_EN != 0) && (REPEAT_EN != 1)) begin : g_bad_repeat_en
    $error("pb_debouncer_multi: REPEAT_EN must be 0 or 1");
  end
  if ((ACTIVE_LOW != 0) && (ACTIVE_LOW != 1)) begin : g_bad_active_low
    $error("pb_debouncer_multi: ACTIVE_LOW must be 0 or 1");
  end

  localparam bit REP_EN_B = (REPEAT_EN != 0);
  localparam bit ACT_LO_B = (ACTIVE_LOW != 0);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pb_evt_t evt;

    pb_debounce_ch #(
      .DELAY         (DELAY),
      .LONG_DELAY    (LONG_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .REPEAT_EN     (REP_EN_B),
      .ACTIVE_LOW    (ACT_LO_B)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .pb  (pb[i]),
      .evt (evt)
    );

    assign pressed_status[i] = evt.status;
    assign pressed_pulse[i]  = evt.press;
    assign released_pulse[i] = evt.rel;
    assign long_pulse[i]     = evt.lng;
    assign repeat_pulse[i]   = evt.rpt;
  end

  assign any_pressed = |pressed_status;

endmodule

// File: tb/tb_pb_debouncer_multi.sv
// Directed bench for pb_debouncer_multi: an active-high and an active-low instance get mirrored
// stimulus, and every cycle is compared against hand-derived event timing.
module tb_pb_debouncer_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pb;
  logic [1:0] pb_al;

  logic [1:0] st_h, pp_h, rel_h, lp_h, rp_h;
  logic       any_h;
  logic [1:0] st_l, pp_l, rel_l, lp_l, rp_l;
  logic       any_l;

  logic [10:0] obs_h, obs_l;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign pb_al = ~pb;
  assign obs_h = {any_h, st_h, pp_h, rel_h, lp_h, rp_h};
  assign obs_l = {any_l, st_l, pp_l, rel_l, lp_l, rp_l};

  pb_debouncer_multi #(
    .N_CH(2), .DELAY(4), .LONG_DELAY(16), .REPEAT_PERIOD(8), .REPEAT_EN(1), .ACTIVE_LOW(0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pb             (pb),
    .pressed_status (st_h),
    .pressed_pulse  (pp_h),
    .released_pulse (rel_h),
    .long_pulse     (lp_h),
    .repeat_pulse   (rp_h),
    .any_pressed    (any_h)
  );

  pb_debouncer_multi #(
    .N_CH(2), .DELAY(4), .LONG_DELAY(16), .REPEAT_PERIOD(8), .REPEAT_EN(1), .ACTIVE_LOW(1)
  ) dut_al (
    .clk            (clk),
    .rst            (rst),
    .pb             (pb_al),
    .pressed_status (st_l),
    .pressed_pulse  (pp_l),
    .released_pulse (rel_l),
    .long_pulse     (lp_l),
    .repeat_pulse   (rp_l),
    .any_pressed    (any_l)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [1:0] st, input logic [1:0] pp,
                                     input logic [1:0] rel, input logic [1:0] lp,
                                     input logic [1:0] rp);
    return {|st, st, pp, rel, lp, rp};
  endfunction

  // Channel 0 held from edge E; c counts the cycle after edge E+c.
  function automatic logic [10:0] press_vec(input int c);
    logic [1:0] st, pp, lp, rp;
    st = (c >= 6)  ? 2'b01 : 2'b00;
    pp = (c == 6)  ? 2'b01 : 2'b00;
    lp = (c == 23) ? 2'b01 : 2'b00;
    rp = ((c >= 31) && (((c - 31) % 8) == 0)) ? 2'b01 : 2'b00;
    return mk(st, pp, 2'b00, lp, rp);
  endfunction

  // Channels in 'ch' released from edge F (k = cycle after F+k); 'held' stays pressed.
  function automatic logic [10:0] rel_vec(input int k, input logic [1:0] ch, input logic [1:0] held);
    logic [1:0] st, rel;
    st  = held | ((k < 6) ? ch : 2'b00);
    rel = (k == 6) ? ch : 2'b00;
    return mk(st, 2'b00, rel, 2'b00, 2'b00);
  endfunction

  task automatic cycle_check(input string tag, input int c, input logic [10:0] e);
    @(negedge clk);
    check($sformatf("%s c=%0d hi", tag, c), {5'd0, obs_h}, {5'd0, e});
    check($sformatf("%s c=%0d lo", tag, c), {5'd0, obs_l}, {5'd0, e});
  endtask

  initial begin
    rst = 1'b1;
    pb  = 2'b00;
    #2 rst = 1'b0;
    #1;
    check("reset hi", {5'd0, obs_h}, 16'd0);
    check("reset lo", {5'd0, obs_l}, 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Idle after reset: the active-low instance sees pb=1 and must stay quiet.
    for (int c = 0; c < 8; c++) cycle_check("idle", c, 11'd0);

    // Clean press with long press and auto-repeat, then release from REPEAT.
    pb = 2'b01;
    for (int c = 0; c <= 50; c++) cycle_check("press", c, press_vec(c));
    pb = 2'b00;
    for (int k = 0; k <= 10; k++) cycle_check("rel_rep", k, rel_vec(k, 2'b01, 2'b00));

    // Press bounce: high for three sampled edges only.
    pb = 2'b01;
    for (int c = 0; c <= 12; c++) begin
      cycle_check("bounce", c, 11'd0);
      if (c == 2) pb = 2'b00;
    end

    // Release glitch in HOLD restarts the long-press count, then a clean release.
    pb = 2'b01;
    for (int c = 0; c <= 34; c++) begin
      cycle_check("glitch", c, mk((c >= 6) ? 2'b01 : 2'b00, (c == 6) ? 2'b01 : 2'b00,
                                  2'b00, (c == 31) ? 2'b01 : 2'b00, 2'b00));
      if (c == 10) pb = 2'b00;
      if (c == 12) pb = 2'b01;
    end
    pb = 2'b00;
    for (int k = 0; k <= 9; k++) cycle_check("rel_clean", k, rel_vec(k, 2'b01, 2'b00));

    // Simultaneous press on both channels, release ch1 alone, then ch0.
    pb = 2'b11;
    for (int c = 0; c <= 9; c++)
      cycle_check("both", c, mk((c >= 6) ? 2'b11 : 2'b00, (c == 6) ? 2'b11 : 2'b00,
                                2'b00, 2'b00, 2'b00));
    pb = 2'b01;
    for (int k = 0; k <= 9; k++) cycle_check("rel_ch1", k, rel_vec(k, 2'b10, 2'b01));
    pb = 2'b00;
    for (int k = 0; k <= 9; k++) cycle_check("rel_ch0", k, rel_vec(k, 2'b01, 2'b00));

    // Asynchronous reset while in REPEAT, then recovery with the button still held.
    pb = 2'b01;
    for (int c = 0; c <= 35; c++) cycle_check("pre_rst", c, press_vec(c));
    #2 rst = 1'b0;
    #1;
    check("async_rst hi", {5'd0, obs_h}, 16'd0);
    check("async_rst lo", {5'd0, obs_l}, 16'd0);
    cycle_check("in_rst", 0, 11'd0);
    rst = 1'b1;
    for (int c = 0; c <= 32; c++) cycle_check("post_rst", c, press_vec(c));
    pb = 2'b00;
    for (int k = 0; k <= 9; k++) cycle_check("rel_end", k, rel_vec(k, 2'b01, 2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pb_debouncer_multi.md
Name: pb_debouncer_multi

Overview:
- Multi-channel push-button conditioner. Each of N_CH raw asynchronous inputs gets its own 2-FF synchroniser and debounce FSM.
- Per-channel outputs: level status, press pulse, release pulse, long-press pulse and auto-repeat pulses.
- Both the press edge and the release edge are debounced.
- Sits between board buttons and the UI/control logic; replaces single-button debouncers wherever several buttons or hold-to-repeat behaviour is needed.

Parameters:
- N_CH, 4, number of independent button channels (>=1).
- DELAY, 15, consecutive stable cycles required to accept a press or a release (>=2).
- LONG_DELAY, 1000, cycles a press must persist in HOLD before long_pulse fires (>DELAY).
- REPEAT_PERIOD, 200, cycles between repeat_pulse assertions after a long press (>=2).
- REPEAT_EN, 1, 1 enables auto-repeat; 0 keeps REPEAT silent.
- ACTIVE_LOW, 0, 1 means a raw input of 0 is "pressed".

Ports:
- clk  in  1  base clock
- rst  in  1  asynchronous, active-low reset
- pb  in  N_CH  raw asynchronous button inputs
- pressed_status  out  N_CH  debounced level, high while the button is accepted as pressed
- pressed_pulse  out  N_CH  one-cycle pulse on an accepted press
- released_pulse  out  N_CH  one-cycle pulse on an accepted release
- long_pulse  out  N_CH  one-cycle pulse when the press reaches LONG_DELAY
- repeat_pulse  out  N_CH  one-cycle pulses every REPEAT_PERIOD cycles after long_pulse
- any_pressed  out  1  OR of pressed_status

Behaviour:
- Reset:
  - rst low clears all state asynchronously: FSMs go to IDLE, timers to 0, all outputs 0 with no clock edge needed.
  - Synchroniser flops reset to the not-pressed level: 0, or 1 when ACTIVE_LOW=1.
  - rst deassertion is synchronised upstream.
- Synchronisation:
  - s = second synchroniser flop, XOR ACTIVE_LOW, so 1 always means "pressed".
  - A raw change sampled at edge E appears on s after edge E+1.
- Per-channel timer: clog2(max(DELAY,LONG_DELAY,REPEAT_PERIOD)) bits. It clears on every state change and otherwise increments; it never wraps except as stated under REPEAT.
- State transitions (checked each edge):
  - IDLE: s=1 -> PRESS_CNT.
  - PRESS_CNT: s=0 -> IDLE, no output. s=1 with timer==DELAY-1 -> PRESSED.
  - PRESSED: one cycle; pressed_pulse=1; -> HOLD.
  - HOLD: s=0 -> REL_CNT. s=1 with timer==LONG_DELAY-1 -> LONG.
  - LONG: one cycle; long_pulse=1; -> REPEAT.
  - REPEAT:
    - s=0 -> REL_CNT.
    - When timer==REPEAT_PERIOD-1 and s=1: repeat_pulse=REPEAT_EN (Mealy) and timer wraps to 0.
  - REL_CNT:
    - s=1 -> HOLD. This is a release glitch: no release is reported and the LONG_DELAY count restarts.
    - s=0 with timer==DELAY-1 -> RELEASED.
  - RELEASED: one cycle; released_pulse=1; -> IDLE.
- Output rules:
  - pressed_status=1 in PRESSED, HOLD, LONG, REPEAT and REL_CNT.
  - All pulses are exactly one cycle wide; at most one pulse type is active per channel per cycle.
- Latency:
  - Raw press stable from edge E: pressed_pulse is high in the cycle after edge E+2+DELAY.
  - Release: same latency, measured on released_pulse.
- Channel independence: channels share only clk/rst. Simultaneous events on different channels are all reported in the same cycle.
- Illegal parameters (values outside the ranges above) stop elaboration with $error.

Decomposition:
- Shared package pb_pkg:
  - enum pb_state_t {IDLE, PRESS_CNT, PRESSED, HOLD, LONG, REPEAT, REL_CNT, RELEASED}, 3 bits.
  - Timer-width function.
- Sub-module pb_debounce_ch: synchroniser, timer and FSM for one channel. Instantiated N_CH times in a generate loop; the top also adds the any_pressed OR.

Test Plan (N_CH=2, DELAY=4, LONG_DELAY=16, REPEAT_PERIOD=8, REPEAT_EN=1):
- Clean press: pb[0]=1 from edge E, held 50 cycles ->
  - pressed_pulse[0] in the cycle after E+6; pressed_status[0] and any_pressed high from then.
  - long_pulse[0] after E+23.
  - repeat_pulse[0] after E+31, E+39, E+47.
  - No activity on channel 1.
- Press bounce: pb[0] high 3 cycles, then low -> all outputs stay 0; FSM back to IDLE.
- Release glitch and clean release:
  - In HOLD, pb[0] low 2 cycles then high -> no released_pulse; status stays 1.
  - Then pb[0] low from edge F -> released_pulse[0] one cycle after F+6; status falls with it.
- Simultaneous channels: pb[1:0]=2'b11 at the same edge -> both pressed_pulse bits high in the same cycle; release of ch1 only -> released_pulse=2'b10.
- ACTIVE_LOW=1: pb idles at 1 and drops to 0 -> identical timing to the clean-press test. After reset with pb=1, no spurious press is reported.
- Async reset mid-REPEAT: rst low between edges -> all outputs 0 immediately. After rst high with pb still held -> a fresh pressed_pulse 7 cycles later, and long_pulse only after a full LONG_DELAY.
